// File: rtl/edac_err_stats_pkg.sv
// Shared types and helpers for the EDAC error statistics block:
// read FSM states, counter-select encoding, all-ones constant.
package edac_err_stats_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } rd_state_t;

    // rd_sel = 2*ch + kind
    localparam int unsigned SEL_SBE = 0;
    localparam int unsigned SEL_DBE = 1;

    function automatic int unsigned cnt_idx(
        input int unsigned ch,
        input int unsigned kind
    );
        return 2 * ch + kind;
    endfunction

    // Saturation value of a w-bit counter (w <= 32)
    function automatic logic [31:0] all_ones(
        input int unsigned w
    );
        if (w >= 32)
            return 32'hFFFF_FFFF;
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/edac_err_stats_sat_counter.sv
// Saturating up-counter with synchronous clear (clr+inc loads 1).
// Ports: CLK, nRESET, inc, clr -> cnt, at_max.
module edac_err_stats_sat_counter
    import edac_err_stats_pkg::*;
#(
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   CLK,
    input  logic                   nRESET,
    input  logic                   inc,
    input  logic                   clr,
    output logic [COUNT_WIDTH-1:0] cnt,
    output logic                   at_max
);

    localparam logic [COUNT_WIDTH-1:0] MAX =
        COUNT_WIDTH'(all_ones(COUNT_WIDTH));
    localparam logic [COUNT_WIDTH-1:0] ONE = 1;

    assign at_max = (cnt == MAX);

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET)
            cnt <= '0;
        else if (clr)
            cnt <= inc ? ONE : '0;
        else if (inc && !at_max)
            cnt <= cnt + ONE;
    end

endmodule

// File: rtl/edac_err_stats.sv
// Per-channel SBE/DBE saturating error counters with a one-cycle
// req/ack read port (optional clear-on-read), sticky sat flags and
// a sticky DBE interrupt.
// Ports: CLK, nRESET, err_valid/err_ch/err_sbe/err_dbe (events),
//   rd_req/rd_sel/rd_clr -> rd_ack/rd_data (read), sat, irq_dbe,
//   irq_clr.
// Optional macro EDAC_SBE_THRESH_EN adds thresh_wr/thresh_val and
//   irq_sbe (SBE count reached a programmable threshold).
module edac_err_stats
    import edac_err_stats_pkg::*;
#(
    parameter int COUNT_WIDTH = 8,
    parameter int NUM_CH      = 2,
    parameter int SEL_W       = 4
) (
    input  logic                   CLK,
    input  logic                   nRESET,
    input  logic                   err_valid,
    input  logic [2:0]             err_ch,
    input  logic                   err_sbe,
    input  logic                   err_dbe,
    input  logic                   rd_req,
    input  logic [SEL_W-1:0]       rd_sel,
    input  logic                   rd_clr,
    output logic                   rd_ack,
    output logic [COUNT_WIDTH-1:0] rd_data,
    output logic [NUM_CH-1:0]      sat,
`ifdef EDAC_SBE_THRESH_EN
    input  logic                   thresh_wr,
    input  logic [COUNT_WIDTH-1:0] thresh_val,
    output logic                   irq_sbe,
`endif
    output logic                   irq_dbe,
    input  logic                   irq_clr
);

    localparam int NCNT = 2 * NUM_CH;
    localparam logic [COUNT_WIDTH-1:0] MAX =
        COUNT_WIDTH'(all_ones(COUNT_WIDTH));
    localparam logic [COUNT_WIDTH-1:0] ONE = 1;

    rd_state_t state, state_nx;
    logic      rd_take;
    logic      ev;

    logic [COUNT_WIDTH-1:0] cnt [NCNT];
    logic [COUNT_WIDTH-1:0] nxt [NCNT];
    logic [NCNT-1:0]        inc;
    logic [NCNT-1:0]        clr;
    logic [NCNT-1:0]        at_max;
    logic [NCNT-1:0]        nxt_max;
    logic [COUNT_WIDTH-1:0] sel_cnt;
    logic [NUM_CH-1:0]      sat_nx;

    assign ev = err_valid && (32'(err_ch) < NUM_CH);

    // Read FSM
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        rd_take  = 1'b0;
        unique case (state)
            IDLE: begin
                if (rd_req) begin
                    rd_take  = 1'b1;
                    state_nx = ACK;
                end
            end
            ACK: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign rd_ack = (state == ACK);

    // Counters
    for (genvar i = 0; i < NCNT; i++) begin : g_cnt
        localparam int CH = i / 2;
        localparam bit IS_DBE = ((i % 2) == SEL_DBE);
        logic hit;

        assign hit = ev && (err_ch == 3'(CH));

        // A combined SBE+DBE report counts only as DBE
        if (IS_DBE) begin : g_dbe
            assign inc[i] = hit && err_dbe;
        end else begin : g_sbe
            assign inc[i] = hit && err_sbe && !err_dbe;
        end

        assign clr[i] = rd_take && rd_clr &&
                        (rd_sel == SEL_W'(i));

        // Post-edge value, mirrors the counter's own update
        assign nxt[i] = clr[i] ? (inc[i] ? ONE : '0) :
                        (inc[i] && !at_max[i]) ?
                        cnt[i] + ONE : cnt[i];
        assign nxt_max[i] = (nxt[i] == MAX);

        edac_err_stats_sat_counter #(
            .COUNT_WIDTH(COUNT_WIDTH)
        ) u_cnt (
            .CLK   (CLK),
            .nRESET(nRESET),
            .inc   (inc[i]),
            .clr   (clr[i]),
            .cnt   (cnt[i]),
            .at_max(at_max[i])
        );
    end

    // Read mux: out-of-range selects return 0
    always_comb begin
        sel_cnt = '0;
        for (int i = 0; i < NCNT; i++)
            if (rd_sel == SEL_W'(i))
                sel_cnt = cnt[i];
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET)
            rd_data <= '0;
        else if (rd_take)
            rd_data <= sel_cnt;
    end

    // Sticky saturation: a clear-read re-evaluates from the
    // post-edge counter values, otherwise only sets.
    always_comb begin
        sat_nx = sat;
        for (int c = 0; c < NUM_CH; c++) begin
            if (clr[cnt_idx(c, SEL_SBE)] ||
                clr[cnt_idx(c, SEL_DBE)])
                sat_nx[c] = nxt_max[cnt_idx(c, SEL_SBE)] ||
                            nxt_max[cnt_idx(c, SEL_DBE)];
            else if (nxt_max[cnt_idx(c, SEL_SBE)] ||
                     nxt_max[cnt_idx(c, SEL_DBE)])
                sat_nx[c] = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET)
            sat <= '0;
        else
            sat <= sat_nx;
    end

    // Set wins over clear
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET)
            irq_dbe <= 1'b0;
        else if (ev && err_dbe)
            irq_dbe <= 1'b1;
        else if (irq_clr)
            irq_dbe <= 1'b0;
    end

`ifdef EDAC_SBE_THRESH_EN
    logic [COUNT_WIDTH-1:0] thresh;
    logic                   sbe_hit;

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET)
            thresh <= MAX;
        else if (thresh_wr)
            thresh <= thresh_val;
    end

    // Only a real increment that lands on the threshold counts
    always_comb begin
        sbe_hit = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (inc[cnt_idx(c, SEL_SBE)] &&
                (clr[cnt_idx(c, SEL_SBE)] ||
                 !at_max[cnt_idx(c, SEL_SBE)]) &&
                (nxt[cnt_idx(c, SEL_SBE)] == thresh))
                sbe_hit = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET)
            irq_sbe <= 1'b0;
        else if (sbe_hit)
            irq_sbe <= 1'b1;
        else if (irq_clr)
            irq_sbe <= 1'b0;
    end
`endif

endmodule

// File: doc/edac_err_stats.md
Name: edac_err_stats

Overview:
- Multi-channel EDAC error statistics block; successor to the single 8-bit EDAC error counter.
- Keeps a separate saturating count of correctable (single-bit, SBE) and uncorrectable (double-bit, DBE) errors for each of NUM_CH memory channels.
- Counters are read through a one-cycle request/acknowledge port with optional clear-on-read.
- Raises a sticky interrupt on any DBE. Sits between the EDAC decoders and the IHU register bus.

Parameters:
- COUNT_WIDTH, 8, bits per counter.
- NUM_CH, 2, number of memory channels (1..8).
- SEL_W, 4, width of rd_sel; must satisfy 2^SEL_W >= 2*NUM_CH.

Ports:
- CLK  input  1  system clock; all logic on rising edge.
- nRESET  input  1  asynchronous active-low reset.
- err_valid  input  1  one-cycle strobe: EDAC check result valid this cycle.
- err_ch  input  3  channel index of the checked access.
- err_sbe  input  1  single-bit error corrected (qualified by err_valid).
- err_dbe  input  1  double-bit error detected (qualified by err_valid).
- rd_req  input  1  one-cycle read request.
- rd_sel  input  SEL_W  counter select: 2*ch = SBE count of ch, 2*ch+1 = DBE count of ch.
- rd_clr  input  1  clear selected counter as part of this read.
- rd_ack  output  1  read data valid, one cycle.
- rd_data  output  COUNT_WIDTH  read data.
- sat  output  NUM_CH  per-channel sticky flag: either counter of that channel has saturated.
- irq_dbe  output  1  sticky DBE interrupt.
- irq_clr  input  1  clears irq_dbe.

Behaviour:
- Reset: all counters, sat, rd_ack, rd_data and irq_dbe = 0; read FSM returns to IDLE.
- Error event (err_valid=1, err_ch<NUM_CH):
  - err_sbe increments SBE[err_ch]; err_dbe increments DBE[err_ch] on the same edge.
  - If both are set, only DBE is incremented.
  - err_ch >= NUM_CH: event ignored.
- Saturation:
  - A counter at all-ones holds; it never wraps.
  - sat[ch] sets on the edge that takes either counter of ch to all-ones.
  - sat[ch] clears only on reset, or when a clear-read of that channel leaves both counters below all-ones.
- Read FSM, states IDLE and ACK:
  - IDLE + rd_req: capture the selected counter into rd_data, go to ACK.
  - ACK: rd_ack=1 for exactly one cycle, then IDLE.
  - rd_req while in ACK is ignored; the requester must wait for rd_ack.
  - rd_data holds its value after ACK until the next captured read.
  - Latency: rd_ack one cycle after rd_req.
- rd_sel decode: an out-of-range rd_sel (>=2*NUM_CH) returns 0; a clear on it has no effect.
- Clear-on-read (rd_clr=1 with accepted rd_req): the selected counter is cleared on the capture edge.
- Simultaneous increment and clear of the same counter on one edge:
  - rd_data = pre-increment value.
  - Counter becomes 1; the event is never lost.
- Simultaneous increment and non-clearing read: rd_data = pre-increment value; counter increments.
- irq_dbe:
  - Set on any counted DBE event, including when DBE is saturated.
  - irq_clr clears it.
  - If set and clear occur on the same edge, set wins.
- Reset asserted mid-read: rd_ack is dropped immediately (asynchronous); the read is lost.

Optional Feature:
- Macro: EDAC_SBE_THRESH_EN.
- Defined:
  - Adds input thresh_wr (1), thresh_val (COUNT_WIDTH) and output irq_sbe (1).
  - thresh_wr loads a shared threshold register (reset value all-ones).
  - irq_sbe is sticky; it sets on the edge any SBE counter increments to a value equal to the threshold.
  - irq_sbe is cleared by irq_clr with the same set-wins rule as irq_dbe.
- Undefined: those ports and the threshold register are absent; behaviour is otherwise identical.

Decomposition:
- Shared package: read FSM state encoding (IDLE/ACK), the counter-select encoding (SBE=even, DBE=odd) and the all-ones saturation constant function.
- Sub-module sat_counter:
  - COUNT_WIDTH-wide saturating counter with inc and clr inputs (clr+inc gives 1) and an at_max output.
  - Instantiated 2*NUM_CH times via generate.

Test Plan:
- Reset, then read rd_sel=0..3 (NUM_CH=2) -> each rd_ack one cycle after rd_req, rd_data=0, sat=0, irq_dbe=0.
- 5 SBE events on ch1, then read rd_sel=2 without clear, then again with rd_clr -> 5, 5; a third read returns 0.
- 300 SBE events on ch0 with COUNT_WIDTH=8 -> read rd_sel=0 returns 255; sat[0]=1. A clear-read then gives sat[0]=0 and next read 0.
- SBE event on ch0 on the same edge as a clear-read of rd_sel=0 while count=7 -> rd_data=7; next read returns 1.
- err_sbe=err_dbe=1 on ch1 -> DBE[1]=1, SBE[1]=0, irq_dbe=1. irq_clr with a coincident DBE keeps irq_dbe=1; a later lone irq_clr gives 0.
- With EDAC_SBE_THRESH_EN, threshold=3: 3 SBE events on ch0 -> irq_sbe rises on the third; err_ch=5 events and rd_sel=6 reads do nothing and return 0.
